// File: rtl/cv_pad_scanner_if.sv
// Pad-side pins and host-side results of the ColecoVision controller scanner.
// master = scanner, slave = pads plus the host consuming joy/key/evt.
interface cv_pad_scanner_if;
  logic [1:0]  ctrl_p1_i;
  logic [1:0]  ctrl_p2_i;
  logic [1:0]  ctrl_p3_i;
  logic [1:0]  ctrl_p4_i;
  logic [1:0]  ctrl_p6_i;
  logic [1:0]  ctrl_p5_o;
  logic [1:0]  ctrl_p8_o;
  logic [15:0] joy0_o;
  logic [15:0] joy1_o;
  logic [3:0]  key0_o;
  logic [3:0]  key1_o;
  logic [10:0] evt_o;

  modport master (
    input  ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i,
    output ctrl_p5_o, ctrl_p8_o, joy0_o, joy1_o, key0_o, key1_o, evt_o
  );

  modport slave (
    output ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i,
    input  ctrl_p5_o, ctrl_p8_o, joy0_o, joy1_o, key0_o, key1_o, evt_o
  );
endinterface

// File: rtl/cv_pad_scanner.sv
// Scans two ColecoVision pads (joystick then keypad half), debounces each port
// and emits joystick words, keypad codes and toggle-style key events.
//
// state  | meaning
// GAP    | both selects high, idle between rounds
// SEL_J  | joystick select low, settling
// SAMP_J | latch direction/fire pins
// SEL_K  | keypad select low, settling
// SAMP_K | latch keypad nibble and arm
// COMMIT | debounce, update outputs, load event queue
module cv_pad_scanner #(
  parameter int SETTLE_CYC = 32,
  parameter int GAP_CYC    = 1024,
  parameter int DEBOUNCE   = 3
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clk_en_i,
  cv_pad_scanner_if.master  pad
);

  typedef enum logic [2:0] {GAP, SEL_J, SAMP_J, SEL_K, SAMP_K, COMMIT} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  p5, p8;
  logic [4:0]  joy_lat [2];
  logic [3:0]  nib [2];
  logic [1:0]  arm;
  logic [15:0] joy_q [2];
  logic [15:0] prev_word [2];
  logic [3:0]  key_q [2];
  logic [3:0]  prev_key [2];
  logic [2:0]  db_cnt [2];
  logic [5:0]  q_ent [4];
  logic [2:0]  q_cnt;
  logic [10:0] evt;

  logic [3:0]  cand_key [2];
  logic [15:0] cand_word [2];
  logic [2:0]  nxt_cnt [2];
  logic [1:0]  upd, key_chg;
  logic [5:0]  push_ent [4];
  logic [2:0]  push_n;

  function automatic logic [3:0] decode(input logic [3:0] n);
    case (n)
      4'b0011: return 4'd0;
      4'b1110: return 4'd1;
      4'b1101: return 4'd2;
      4'b0110: return 4'd3;
      4'b0001: return 4'd4;
      4'b1001: return 4'd5;
      4'b0111: return 4'd6;
      4'b1100: return 4'd7;
      4'b1000: return 4'd8;
      4'b1011: return 4'd9;
      4'b1010: return 4'd10;
      4'b0101: return 4'd11;
      4'b0100: return 4'd12;
      4'b0010: return 4'd13;
      default: return 4'd15;
    endcase
  endfunction

  always_comb begin
    upd     = '0;
    key_chg = '0;
    for (int p = 0; p < 2; p++) begin
      cand_key[p]  = decode(nib[p]);
      cand_word[p] = {2'b00, cand_key[p] == 4'd13, cand_key[p] == 4'd12,
                      cand_key[p] == 4'd3, cand_key[p] == 4'd2,
                      cand_key[p] == 4'd1, cand_key[p] == 4'd0,
                      cand_key[p] == 4'd11, cand_key[p] == 4'd10,
                      arm[p], joy_lat[p]};
      if (cand_word[p] == prev_word[p] && cand_key[p] == prev_key[p])
        nxt_cnt[p] = (db_cnt[p] == 3'd7) ? 3'd7 : db_cnt[p] + 3'd1;
      else
        nxt_cnt[p] = 3'd1;
      upd[p] = (state == COMMIT) && (nxt_cnt[p] >= 3'(DEBOUNCE)) &&
               (cand_word[p] != joy_q[p] || cand_key[p] != key_q[p]);
      key_chg[p] = upd[p] && (cand_key[p] != key_q[p]);
    end
  end

  // Compact up to four events (release before press, port 0 before port 1).
  always_comb begin
    push_n = 3'd0;
    for (int i = 0; i < 4; i++) push_ent[i] = 6'd0;
    for (int p = 0; p < 2; p++) begin
      if (key_chg[p]) begin
        if (key_q[p] != 4'd15) begin
          push_ent[push_n[1:0]] = {1'b0, 1'(p), key_q[p]};
          push_n = push_n + 3'd1;
        end
        if (cand_key[p] != 4'd15) begin
          push_ent[push_n[1:0]] = {1'b1, 1'(p), cand_key[p]};
          push_n = push_n + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= GAP;
      cnt   <= 16'(GAP_CYC - 1);
      p5    <= 2'b11;
      p8    <= 2'b11;
      arm   <= '0;
      q_cnt <= '0;
      evt   <= '0;
      for (int p = 0; p < 2; p++) begin
        joy_lat[p]   <= '0;
        nib[p]       <= 4'b1111;
        joy_q[p]     <= '0;
        key_q[p]     <= 4'd15;
        prev_word[p] <= '0;
        prev_key[p]  <= 4'd15;
        db_cnt[p]    <= '0;
      end
      for (int i = 0; i < 4; i++) q_ent[i] <= '0;
    end else if (clk_en_i) begin
      case (state)
        GAP:
          if (cnt == 16'd0) begin
            state <= SEL_J;
            cnt   <= 16'(SETTLE_CYC - 1);
            p8    <= 2'b00;
          end else cnt <= cnt - 16'd1;
        SEL_J:
          if (cnt == 16'd0) state <= SAMP_J;
          else cnt <= cnt - 16'd1;
        SAMP_J: begin
          for (int p = 0; p < 2; p++)
            joy_lat[p] <= {~pad.ctrl_p6_i[p], ~pad.ctrl_p1_i[p], ~pad.ctrl_p2_i[p],
                           ~pad.ctrl_p3_i[p], ~pad.ctrl_p4_i[p]};
          p8    <= 2'b11;
          p5    <= 2'b00;
          state <= SEL_K;
          cnt   <= 16'(SETTLE_CYC - 1);
        end
        SEL_K:
          if (cnt == 16'd0) state <= SAMP_K;
          else cnt <= cnt - 16'd1;
        SAMP_K: begin
          for (int p = 0; p < 2; p++)
            nib[p] <= {pad.ctrl_p1_i[p], pad.ctrl_p2_i[p], pad.ctrl_p3_i[p], pad.ctrl_p4_i[p]};
          arm   <= ~pad.ctrl_p6_i;
          p5    <= 2'b11;
          state <= COMMIT;
        end
        COMMIT: begin
          for (int p = 0; p < 2; p++) begin
            prev_word[p] <= cand_word[p];
            prev_key[p]  <= cand_key[p];
            db_cnt[p]    <= nxt_cnt[p];
            if (upd[p]) begin
              joy_q[p] <= cand_word[p];
              key_q[p] <= cand_key[p];
            end
          end
          state <= GAP;
          cnt   <= 16'(GAP_CYC - 1);
        end
        default: begin
          state <= GAP;
          cnt   <= 16'(GAP_CYC - 1);
        end
      endcase

      // Queue is always empty at COMMIT: a round is far longer than four pops.
      if (state == COMMIT) begin
        for (int i = 0; i < 4; i++) q_ent[i] <= push_ent[i];
        q_cnt <= push_n;
      end else if (q_cnt != 3'd0) begin
        evt      <= {~evt[10], q_ent[0][5:4], 4'b0000, q_ent[0][3:0]};
        q_ent[0] <= q_ent[1];
        q_ent[1] <= q_ent[2];
        q_ent[2] <= q_ent[3];
        q_ent[3] <= '0;
        q_cnt    <= q_cnt - 3'd1;
      end
    end
  end

  assign pad.ctrl_p5_o = p5;
  assign pad.ctrl_p8_o = p8;
  assign pad.joy0_o    = joy_q[0];
  assign pad.joy1_o    = joy_q[1];
  assign pad.key0_o    = key_q[0];
  assign pad.key1_o    = key_q[1];
  assign pad.evt_o     = evt;

endmodule

// File: tb/tb_cv_pad_scanner.sv
// Directed bench for cv_pad_scanner: two modelled pads answer the select lines,
// expected words/codes/events are hand-computed.
module tb_cv_pad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;

  cv_pad_scanner_if pad ();

  cv_pad_scanner #(.SETTLE_CYC(4), .GAP_CYC(8), .DEBOUNCE(3)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .clk_en_i (clk_en),
    .pad      (pad)
  );

  always #5 clk = ~clk;

  // Pin patterns {p1,p2,p3,p4,p6}, raw (active low).
  logic [4:0] joy_pat0 = 5'h1f, joy_pat1 = 5'h1f;
  logic [4:0] key_pat0 = 5'h1f, key_pat1 = 5'h1f;
  logic [4:0] pin0, pin1;

  assign pin0 = !pad.ctrl_p8_o[0] ? joy_pat0 : (!pad.ctrl_p5_o[0] ? key_pat0 : 5'h1f);
  assign pin1 = !pad.ctrl_p8_o[1] ? joy_pat1 : (!pad.ctrl_p5_o[1] ? key_pat1 : 5'h1f);
  assign pad.ctrl_p1_i = {pin1[4], pin0[4]};
  assign pad.ctrl_p2_i = {pin1[3], pin0[3]};
  assign pad.ctrl_p3_i = {pin1[2], pin0[2]};
  assign pad.ctrl_p4_i = {pin1[1], pin0[1]};
  assign pad.ctrl_p6_i = {pin1[0], pin0[0]};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns at the negedge just after the next COMMIT edge.
  task automatic next_commit();
    int i;
    i = 0;
    while (pad.ctrl_p5_o !== 2'b00 && i < 200) begin @(negedge clk); i++; end
    chk("wait_p5_low", 32'(i < 200), 1);
    i = 0;
    while (pad.ctrl_p5_o !== 2'b11 && i < 200) begin @(negedge clk); i++; end
    chk("wait_p5_high", 32'(i < 200), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rounds(input int n);
    for (int r = 0; r < n; r++) next_commit();
  endtask

  // Release reset at a negedge and time the first two select edges.
  task automatic release_and_time();
    int n;
    rst_n = 1'b1;
    n = 0;
    while (pad.ctrl_p8_o !== 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk("p8_fall_cycles", n, 8);
    while (pad.ctrl_p5_o !== 2'b00 && n < 100) begin @(negedge clk); n++; end
    chk("p5_fall_cycles", n, 13);
    chk("p8_high_at_selk", pad.ctrl_p8_o, 2'b11);
  endtask

  initial begin
    int i;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_p5", pad.ctrl_p5_o, 2'b11);
    chk("rst_p8", pad.ctrl_p8_o, 2'b11);
    chk("rst_joy0", pad.joy0_o, 16'h0);
    chk("rst_key0", pad.key0_o, 4'd15);
    chk("rst_key1", pad.key1_o, 4'd15);
    chk("rst_evt", pad.evt_o, 11'h0);
    release_and_time();
    rounds(2);
    chk("idle_joy0", pad.joy0_o, 16'h0);
    chk("idle_joy1", pad.joy1_o, 16'h0);
    chk("idle_key0", pad.key0_o, 4'd15);
    chk("idle_key1", pad.key1_o, 4'd15);
    chk("idle_evt", pad.evt_o, 11'h0);

    // Port 0 up: debounced on the third round only
    joy_pat0 = 5'b01111;
    rounds(1);
    chk("up_r1", pad.joy0_o, 16'h0);
    rounds(1);
    chk("up_r2", pad.joy0_o, 16'h0);
    rounds(1);
    chk("up_r3", pad.joy0_o, 16'h0008);
    chk("up_joy1", pad.joy1_o, 16'h0);
    chk("up_key0", pad.key0_o, 4'd15);
    joy_pat0 = 5'h1f;
    rounds(3);
    chk("up_clear", pad.joy0_o, 16'h0);
    chk("up_noevt", pad.evt_o, 11'h0);

    // Port 1 keypad 9
    key_pat1 = 5'b10111;
    rounds(3);
    chk("k9_key1", pad.key1_o, 4'd9);
    chk("k9_joy1", pad.joy1_o, 16'h0);
    chk("k9_evt_pre", pad.evt_o, 11'h0);
    @(negedge clk);
    chk("k9_evt", pad.evt_o, 11'h709);
    repeat (5) @(negedge clk);
    chk("k9_evt_once", pad.evt_o, 11'h709);

    // Port 0 key 1 then key 2
    key_pat0 = 5'b11101;
    rounds(3);
    chk("k1_key0", pad.key0_o, 4'd1);
    chk("k1_joy0", pad.joy0_o, 16'h0200);
    @(negedge clk);
    chk("k1_evt", pad.evt_o, 11'h201);
    key_pat0 = 5'b11011;
    rounds(3);
    chk("k2_key0", pad.key0_o, 4'd2);
    chk("k2_joy0", pad.joy0_o, 16'h0400);
    @(negedge clk);
    chk("k2_evt_rel", pad.evt_o, 11'h401);
    @(negedge clk);
    chk("k2_evt_prs", pad.evt_o, 11'h202);

    // Alternating nibble never settles
    for (int r = 0; r < 6; r++) begin
      key_pat0 = (r % 2 == 0) ? 5'b11101 : 5'b11011;
      next_commit();
      chk("alt_key0", pad.key0_o, 4'd2);
    end
    chk("alt_joy0", pad.joy0_o, 16'h0400);
    chk("alt_evt", pad.evt_o, 11'h202);

    // clk_en low freezes the scan inside SEL_J
    i = 0;
    while (pad.ctrl_p8_o !== 2'b00 && i < 200) begin @(negedge clk); i++; end
    chk("wait_p8_low", 32'(i < 200), 1);
    clk_en = 1'b0;
    repeat (40) @(negedge clk);
    chk("frz_p8", pad.ctrl_p8_o, 2'b00);
    chk("frz_p5", pad.ctrl_p5_o, 2'b11);
    clk_en = 1'b1;
    next_commit();
    chk("frz_key0", pad.key0_o, 4'd2);

    // Reset in the middle of SEL_K
    i = 0;
    while (pad.ctrl_p5_o !== 2'b00 && i < 200) begin @(negedge clk); i++; end
    chk("wait_selk", 32'(i < 200), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_p5", pad.ctrl_p5_o, 2'b11);
    chk("mid_joy0", pad.joy0_o, 16'h0);
    chk("mid_key0", pad.key0_o, 4'd15);
    chk("mid_key1", pad.key1_o, 4'd15);
    chk("mid_evt", pad.evt_o, 11'h0);
    repeat (2) @(negedge clk);
    release_and_time();
    rounds(3);
    chk("re_key0", pad.key0_o, 4'd2);
    chk("re_key1", pad.key1_o, 4'd9);
    chk("re_joy0", pad.joy0_o, 16'h0400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
